// File: rtl/ps2_key_tracker.sv
// ps2_key_tracker
//
// Pops PS/2 Set-2 scan-code bytes from the upstream receiver FIFO and keeps
// track of the single most recently pressed key. E0 marks the next code as
// extended and F0 marks it as a break. Typematic repeats of the held key are
// suppressed, so press_cnt counts only distinct presses.
//
// Ports:
//   clk         system clock, all state on the rising edge
//   rst         asynchronous active-high reset
//   ready       FIFO non-empty, data valid
//   data        byte at the FIFO head
//   overflow    FIFO overflow indication
//   nextdata_n  active-low pop, low for exactly one cycle per byte
//   key_code    code of the most recent non-repeat make
//   key_ext     that make was E0-prefixed
//   key_down    key in key_code/key_ext is currently held
//   press_cnt   number of new presses since reset (wraps)
//   make_pulse  one-cycle strobe when a new press is registered
//   ovf_seen    sticky: overflow was sampled high since reset

`timescale 1ns/1ps

module ps2_key_tracker #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ready,
    input  logic [7:0]       data,
    input  logic             overflow,
    output logic             nextdata_n,
    output logic [7:0]       key_code,
    output logic             key_ext,
    output logic             key_down,
    output logic [CNT_W-1:0] press_cnt,
    output logic             make_pulse,
    output logic             ovf_seen
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        POP    = 2'd1,
        SETTLE = 2'd2
    } state_t;

    state_t state_reg;
    state_t state_next;

    logic ext_pend_reg;
    logic brk_pend_reg;
    logic same_key;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next state and the Moore pop strobe. SETTLE gives the FIFO a cycle to
    // advance its read pointer, so ready is never looked at while it may be
    // stale and a byte can never be popped twice.
    always_comb begin
        state_next = state_reg;
        nextdata_n = 1'b1;
        case (state_reg)
            IDLE: begin
                if (ready) begin
                    state_next = POP;
                end
            end
            POP: begin
                nextdata_n = 1'b0;
                state_next = SETTLE;
            end
            SETTLE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // The incoming code names the key currently tracked as held: a make of
    // it is a typematic repeat, a break of it releases the key.
    assign same_key = key_down && (data == key_code) && (ext_pend_reg == key_ext);

    // Byte processing happens on the edge that leaves POP.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            key_code     <= 8'h00;
            key_ext      <= 1'b0;
            key_down     <= 1'b0;
            press_cnt    <= '0;
            make_pulse   <= 1'b0;
            ovf_seen     <= 1'b0;
            ext_pend_reg <= 1'b0;
            brk_pend_reg <= 1'b0;
        end else begin
            make_pulse <= 1'b0;

            if (overflow) begin
                ovf_seen <= 1'b1;
            end

            if (state_reg == POP) begin
                if (data == 8'hE0) begin
                    ext_pend_reg <= 1'b1;
                end else if (data == 8'hF0) begin
                    brk_pend_reg <= 1'b1;
                end else begin
                    ext_pend_reg <= 1'b0;
                    brk_pend_reg <= 1'b0;
                    if (brk_pend_reg) begin
                        // Breaks of any key other than the tracked one are
                        // dropped, including a key that was since replaced.
                        if (same_key) begin
                            key_down <= 1'b0;
                        end
                    end else if (!same_key) begin
                        key_code   <= data;
                        key_ext    <= ext_pend_reg;
                        key_down   <= 1'b1;
                        press_cnt  <= press_cnt + 1'b1;
                        make_pulse <= 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_ps2_key_tracker.sv
`timescale 1ns/1ps

module tb_ps2_key_tracker;

    localparam int CNT_W = 8;
    localparam int VW    = 8 + 1 + 1 + CNT_W + 1;

    logic             clk;
    logic             rst;
    logic             ready;
    logic [7:0]       data;
    logic             overflow;
    logic             nextdata_n;
    logic [7:0]       key_code;
    logic             key_ext;
    logic             key_down;
    logic [CNT_W-1:0] press_cnt;
    logic             make_pulse;
    logic             ovf_seen;

    ps2_key_tracker #(.CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .ready      (ready),
        .data       (data),
        .overflow   (overflow),
        .nextdata_n (nextdata_n),
        .key_code   (key_code),
        .key_ext    (key_ext),
        .key_down   (key_down),
        .press_cnt  (press_cnt),
        .make_pulse (make_pulse),
        .ovf_seen   (ovf_seen)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors    = 0;
    int miscompares = 0;
    int pop_cycles = 0;
    int pulse_total = 0;
    int last_lat   = 0;

    // Scoreboard of expected {key_code, key_ext, key_down, press_cnt, make_pulse}
    // right after each byte is consumed.
    logic [VW-1:0] exp_q[$];

    // Reference model state
    logic [7:0]       m_code;
    logic             m_ext;
    logic             m_down;
    logic [CNT_W-1:0] m_cnt;
    logic             m_ext_pend;
    logic             m_brk_pend;

    task automatic model_reset();
        m_code = 8'h00; m_ext = 1'b0; m_down = 1'b0; m_cnt = '0;
        m_ext_pend = 1'b0; m_brk_pend = 1'b0;
    endtask

    task automatic model_byte(input logic [7:0] b);
        logic pulse;
        logic hit;
        pulse = 1'b0;
        hit = m_down && (b == m_code) && (m_ext_pend == m_ext);
        if (b == 8'hE0) begin
            m_ext_pend = 1'b1;
        end else if (b == 8'hF0) begin
            m_brk_pend = 1'b1;
        end else begin
            if (m_brk_pend) begin
                if (hit) m_down = 1'b0;
            end else if (!hit) begin
                m_code = b;
                m_ext  = m_ext_pend;
                m_down = 1'b1;
                m_cnt  = m_cnt + 1'b1;
                pulse  = 1'b1;
            end
            m_ext_pend = 1'b0;
            m_brk_pend = 1'b0;
        end
        exp_q.push_back({m_code, m_ext, m_down, m_cnt, pulse});
    endtask

    // Monitor: whenever the pop strobe is low, capture outputs just after the
    // consuming edge and compare against the scoreboard head.
    always begin
        logic [VW-1:0] obs;
        logic [VW-1:0] exp;
        @(negedge clk);
        if (nextdata_n === 1'b0) begin
            pop_cycles++;
            @(posedge clk);
            #1;
            if (!rst) begin
                obs = {key_code, key_ext, key_down, press_cnt, make_pulse};
                vectors++;
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL sb_unexpected_pop: got %h required no pop", obs);
                end else begin
                    exp = exp_q.pop_front();
                    if (obs !== exp) begin
                        miscompares++;
                        $display("FAIL sb_byte: got %h required %h (code,ext,down,cnt,pulse)", obs, exp);
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (make_pulse === 1'b1) pulse_total++;
    end

    // Present one byte at the FIFO head until the DUT pops it.
    task automatic send_byte(input logic [7:0] b);
        int n;
        model_byte(b);
        @(negedge clk);
        data  = b;
        ready = 1'b1;
        n = 0;
        while (nextdata_n !== 1'b0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        last_lat = n;
        if (n >= 20) begin
            vectors++;
            miscompares++;
            $display("FAIL pop_timeout: got no pop within %0d cycles required pop for byte %h", n, b);
        end
        @(negedge clk);
        ready = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        model_reset();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; ready = 1'b0; data = 8'h00; overflow = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        vectors++;
        if ({nextdata_n, key_code, key_ext, key_down, press_cnt, make_pulse, ovf_seen} !== {1'b1, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0}) begin
            miscompares++;
            $display("FAIL reset_values: got nd=%b code=%h ext=%b down=%b cnt=%h pulse=%b ovf=%b required 1,00,0,0,00,0,0",
                     nextdata_n, key_code, key_ext, key_down, press_cnt, make_pulse, ovf_seen);
        end
        rst = 1'b0;
    endtask

    task automatic test_first_press();
        int p0, q0;
        p0 = pop_cycles; q0 = pulse_total;
        send_byte(8'h1C);
        repeat (3) @(negedge clk);
        vectors++;
        if (last_lat != 1) begin
            miscompares++;
            $display("FAIL first_latency: got %0d required 1", last_lat);
        end
        vectors++;
        if (pop_cycles - p0 != 1) begin
            miscompares++;
            $display("FAIL first_pop_count: got %0d required 1", pop_cycles - p0);
        end
        vectors++;
        if (pulse_total - q0 != 1) begin
            miscompares++;
            $display("FAIL first_pulse_count: got %0d required 1", pulse_total - q0);
        end
        vectors++;
        if ({key_code, key_ext, key_down, press_cnt} !== {8'h1C, 1'b0, 1'b1, 8'd1}) begin
            miscompares++;
            $display("FAIL first_outputs: got code=%h ext=%b down=%b cnt=%0d required 1c,0,1,1",
                     key_code, key_ext, key_down, press_cnt);
        end
    endtask

    task automatic test_repeat();
        int q0;
        logic [7:0] seq [5];
        seq = '{8'h1C, 8'h1C, 8'h1C, 8'hF0, 8'h1C};
        do_reset();
        q0 = pulse_total;
        foreach (seq[i]) send_byte(seq[i]);
        repeat (2) @(negedge clk);
        vectors++;
        if (pulse_total - q0 != 1) begin
            miscompares++;
            $display("FAIL repeat_pulse_count: got %0d required 1", pulse_total - q0);
        end
        vectors++;
        if ({key_code, key_down, press_cnt} !== {8'h1C, 1'b0, 8'd1}) begin
            miscompares++;
            $display("FAIL repeat_outputs: got code=%h down=%b cnt=%0d required 1c,0,1", key_code, key_down, press_cnt);
        end
    endtask

    task automatic test_extended();
        do_reset();
        send_byte(8'hE0);
        send_byte(8'h75);
        vectors++;
        if ({key_code, key_ext, key_down, press_cnt} !== {8'h75, 1'b1, 1'b1, 8'd1}) begin
            miscompares++;
            $display("FAIL ext_make: got code=%h ext=%b down=%b cnt=%0d required 75,1,1,1", key_code, key_ext, key_down, press_cnt);
        end
        send_byte(8'hF0);
        send_byte(8'h75);
        vectors++;
        if (key_down !== 1'b1) begin
            miscompares++;
            $display("FAIL ext_plain_break: got down=%b required 1", key_down);
        end
        send_byte(8'hE0);
        send_byte(8'hF0);
        send_byte(8'h75);
        vectors++;
        if (key_down !== 1'b0) begin
            miscompares++;
            $display("FAIL ext_break: got down=%b required 0", key_down);
        end
    endtask

    task automatic test_replace();
        do_reset();
        send_byte(8'h1C);
        send_byte(8'h32);
        send_byte(8'hF0);
        send_byte(8'h1C);
        vectors++;
        if ({key_code, key_down, press_cnt} !== {8'h32, 1'b1, 8'd2}) begin
            miscompares++;
            $display("FAIL replace_stale_break: got code=%h down=%b cnt=%0d required 32,1,2", key_code, key_down, press_cnt);
        end
        send_byte(8'hF0);
        send_byte(8'h32);
        vectors++;
        if (key_down !== 1'b0) begin
            miscompares++;
            $display("FAIL replace_break: got down=%b required 0", key_down);
        end
    endtask

    // 256 alternating presses at full rate: every byte must be taken with
    // one cycle of latency (3 cycles per byte) and the counter must wrap.
    task automatic test_back_to_back();
        int slow;
        slow = 0;
        do_reset();
        for (int i = 0; i < 256; i++) begin
            send_byte((i % 2 == 0) ? 8'h1C : 8'h32);
            if (last_lat != 1) slow++;
        end
        vectors++;
        if (slow != 0) begin
            miscompares++;
            $display("FAIL b2b_latency: got %0d slow pops required 0", slow);
        end
        vectors++;
        if (press_cnt !== 8'd0) begin
            miscompares++;
            $display("FAIL wrap_count: got %0d required 0", press_cnt);
        end
    endtask

    task automatic test_overflow();
        vectors++;
        if (ovf_seen !== 1'b0) begin
            miscompares++;
            $display("FAIL ovf_before: got %b required 0", ovf_seen);
        end
        @(negedge clk);
        overflow = 1'b1;
        @(negedge clk);
        overflow = 1'b0;
        vectors++;
        if (ovf_seen !== 1'b1) begin
            miscompares++;
            $display("FAIL ovf_set: got %b required 1", ovf_seen);
        end
        repeat (5) @(negedge clk);
        vectors++;
        if (ovf_seen !== 1'b1) begin
            miscompares++;
            $display("FAIL ovf_sticky: got %b required 1", ovf_seen);
        end
    endtask

    task automatic test_reset_in_pop();
        int p0;
        do_reset();
        send_byte(8'h32);
        @(negedge clk);
        data  = 8'h1C;
        ready = 1'b1;
        @(posedge clk);
        #2;
        vectors++;
        if (nextdata_n !== 1'b0) begin
            miscompares++;
            $display("FAIL rip_in_pop: got nd=%b required 0", nextdata_n);
        end
        rst = 1'b1;
        #1;
        vectors++;
        if ({nextdata_n, key_code, key_ext, key_down, press_cnt, make_pulse, ovf_seen} !== {1'b1, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0}) begin
            miscompares++;
            $display("FAIL rip_async: got nd=%b code=%h ext=%b down=%b cnt=%h pulse=%b ovf=%b required 1,00,0,0,00,0,0",
                     nextdata_n, key_code, key_ext, key_down, press_cnt, make_pulse, ovf_seen);
        end
        repeat (2) @(negedge clk);
        model_reset();
        p0 = pop_cycles;
        rst = 1'b0;
        send_byte(8'h1C);
        repeat (6) @(negedge clk);
        vectors++;
        if (pop_cycles - p0 != 1) begin
            miscompares++;
            $display("FAIL rip_single_pop: got %0d required 1", pop_cycles - p0);
        end
        vectors++;
        if ({key_code, key_down, press_cnt} !== {8'h1C, 1'b1, 8'd1}) begin
            miscompares++;
            $display("FAIL rip_after: got code=%h down=%b cnt=%0d required 1c,1,1", key_code, key_down, press_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_first_press();
        test_repeat();
        test_extended();
        test_replace();
        test_back_to_back();
        test_overflow();
        test_reset_in_pop();
        repeat (4) @(negedge clk);
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL sb_drain: got %0d pending required 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1, "simulation time limit");
    end

endmodule

// File: doc/ps2_key_tracker.md
# ps2_key_tracker

Scan-code interpreter that sits directly downstream of `ps2_keyboard` and upstream of the `bcd7seg` display bank in the keyboard top. It pops bytes from the receiver FIFO with the `ready`/`nextdata_n` handshake and decodes PS/2 Set-2 prefixes (`E0` extended, `F0` break). It tracks the currently held key and counts distinct key presses, ignoring typematic repeats. All outputs are registered and stable for direct hex display.

## Interface
Parameters:
- `CNT_W`, 8, width of the press counter (wraps modulo 2^CNT_W).

Ports:
- `clk`  in  1  system clock, all state on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `ready`  in  1  from `ps2_keyboard`: FIFO non-empty, `data` valid.
- `data`  in  8  from `ps2_keyboard`: byte at FIFO head.
- `overflow`  in  1  from `ps2_keyboard`: FIFO overflow indication.
- `nextdata_n`  out  1  to `ps2_keyboard`: active-low pop, low for exactly one cycle per byte.
- `key_code`  out  8  code of the most recent make (non-repeat).
- `key_ext`  out  1  that make was `E0`-prefixed.
- `key_down`  out  1  the key in `key_code`/`key_ext` is currently held.
- `press_cnt`  out  CNT_W  number of new presses since reset.
- `make_pulse`  out  1  one-cycle strobe when a new press is registered.
- `ovf_seen`  out  1  sticky: `overflow` was sampled high since reset.

## Operation
- FSM states: IDLE, POP, SETTLE.
  - IDLE: `nextdata_n`=1; if `ready`=1 go POP, else stay.
  - POP: `nextdata_n`=0 (Moore, decoded from state); `data` sampled and processed on the edge leaving POP; go SETTLE unconditionally.
  - SETTLE: `nextdata_n`=1; lets the FIFO read pointer and `ready` update; go IDLE unconditionally.
- Internal flags `ext_pend`, `brk_pend`, both cleared at reset.
- Byte processing (edge leaving POP):
  - `E0`: `ext_pend`<=1. No other change.
  - `F0`: `brk_pend`<=1. No other change.
  - Other byte B, `brk_pend`=1 (break): if `key_down`=1 and B==`key_code` and `ext_pend`==`key_ext`, then `key_down`<=0. Otherwise ignored. Clear both flags.
  - Other byte B, `brk_pend`=0 (make):
    - Repeat: `key_down`=1 and B==`key_code` and `ext_pend`==`key_ext`. No output change.
    - New press otherwise: `key_code`<=B, `key_ext`<=`ext_pend`, `key_down`<=1, `press_cnt`<=`press_cnt`+1 (mod 2^CNT_W), `make_pulse`<=1.
    - Clear both flags in either case.
- `make_pulse` is high only in the cycle after a new-press update; otherwise it is 0.
- `ovf_seen`<=1 on any edge with `overflow`=1; cleared only by `rst`.
- Only one key is tracked. Pressing a second key while the first is held replaces it. A later break of the first key is then ignored.

## Timing
- Reset values: state IDLE, `nextdata_n`=1, `key_code`=8'h00, `key_ext`=0, `key_down`=0, `press_cnt`=0, `make_pulse`=0, `ovf_seen`=0, `ext_pend`=0, `brk_pend`=0.
- `rst` asserted in any state, including POP, forces the reset values asynchronously. `nextdata_n` returns to 1 immediately; no partial pop completes.
- Latency: `ready` high at edge N puts the FSM in POP after N. `nextdata_n` is low for cycle N..N+1. Outputs update at edge N+1. SETTLE follows, then IDLE at N+2. `ready` is re-sampled at edge N+3.
- Throughput: one byte per 3 cycles, sustained while `ready` stays high.
- `ready` is never sampled in POP or SETTLE, so a stale `ready` cannot cause a double pop.
- Counter wraps from 2^CNT_W−1 to 0 with no flag.

## Test plan
- Reset, then FIFO delivers `1C` → exactly one `nextdata_n` low cycle; `key_code`=1C, `key_ext`=0, `key_down`=1, `press_cnt`=1; `make_pulse` high for one cycle.
- Sequence `1C 1C 1C F0 1C` → `press_cnt` stays 1 and one `make_pulse`; `key_down`=0 after the final byte; `key_code` remains 1C.
- Sequence `E0 75 F0 75` → after `75`: `key_ext`=1, `key_down`=1, cnt=1. Plain `F0 75` is a non-matching break (ext mismatch), so `key_down` stays 1. Following `E0 F0 75` → `key_down`=0.
- Sequence `1C 32 F0 1C` → `key_code`=32, cnt=2, `key_down`=1 (stale break ignored). Then `F0 32` → `key_down`=0.
- CNT_W=8: 256 alternating presses of `1C`/`32` → `press_cnt`=0 after the 256th; pulse `overflow` for one cycle → `ovf_seen`=1 and stays 1.
- Assert `rst` during POP after `ready`→ `nextdata_n` returns to 1 immediately, all outputs at reset values. After release, the still-pending byte is popped exactly once.
